// File: rtl/frame_config_pkg.sv
// Shared definitions for the frame configuration writer: FSM encoding, sync word
// and the bit positions of the fields inside a write-header word.
package frame_config_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HEADER = 2'd1;
  localparam state_t ST_DATA   = 2'd2;
  localparam state_t ST_STROBE = 2'd3;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  localparam int WRITE_BIT = 31;
  localparam int COL_MSB   = 23;
  localparam int COL_LSB   = 16;
  localparam int FRAME_MSB = 15;
  localparam int FRAME_LSB = 8;
  localparam int FIELD_W   = COL_MSB - COL_LSB + 1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame -> one-hot FrameStrobe decoder, zero latency.
// Out-of-range addresses or a low enable give an all-zero strobe vector.
module frame_strobe_decoder
  import frame_config_pkg::*;
#(
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [FIELD_W-1:0]                    column_i,
  input  logic [FIELD_W-1:0]                    frame_i,
  input  logic                                  enable_i,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

  localparam int STROBE_W = NumColumns * MaxFramesPerCol;

  logic hit;
  int   idx;

  assign hit = enable_i && (int'(column_i) < NumColumns) && (int'(frame_i) < MaxFramesPerCol);
  assign idx = int'(column_i) * MaxFramesPerCol + int'(frame_i);

  always_comb begin
    strobe_o = '0;
    for (int i = 0; i < STROBE_W; i++) begin
      strobe_o[i] = hit && (idx == i);
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Word-stream to frame-latch writer: sync, header, NumRows data words, then a
// StrobeCycles-long one-hot strobe one cycle after the last word; WordReady low only while strobing.
module frame_config_writer
  import frame_config_pkg::*;
#(
  parameter int                 FrameBitsPerRow = 32,
  parameter int                 NumRows         = 4,
  parameter int                 MaxFramesPerCol = 20,
  parameter int                 NumColumns      = 4,
  parameter int                 StrobeCycles    = 2,
  parameter logic [31:0]        SyncWord        = SYNC_WORD_DEFAULT
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [FrameBitsPerRow-1:0]            WordData,
  input  logic                                  WordValid,
  output logic                                  WordReady,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  Active,
  output logic                                  Error,
  output logic [15:0]                           FrameCount
);

  localparam int FRAME_W = NumRows * FrameBitsPerRow;
  localparam int WCNT_W  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SCNT_W  = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(NumRows - 1);
  localparam logic [SCNT_W-1:0] LAST_STROBE = SCNT_W'(StrobeCycles - 1);

  state_t               state_q,  state_d;
  logic [FRAME_W-1:0]   frame_q,  frame_d;
  logic [FIELD_W-1:0]   col_q,    col_d;
  logic [FIELD_W-1:0]   frm_q,    frm_d;
  logic                 drop_q,   drop_d;
  logic [WCNT_W-1:0]    wcnt_q,   wcnt_d;
  logic [SCNT_W-1:0]    scnt_q,   scnt_d;
  logic                 error_q,  error_d;
  logic [15:0]          count_q,  count_d;

  logic                 accept;
  logic [FIELD_W-1:0]   hdr_col;
  logic [FIELD_W-1:0]   hdr_frm;
  logic                 hdr_drop;
  logic [FRAME_W-1:0]   shifted;

  // Ready depends on state alone so the source never sees a valid->ready path.
  assign WordReady = (state_q != ST_STROBE);
  assign accept    = WordValid && WordReady;

  assign hdr_col  = WordData[COL_MSB:COL_LSB];
  assign hdr_frm  = WordData[FRAME_MSB:FRAME_LSB];
  assign hdr_drop = (int'(hdr_col) >= NumColumns) || (int'(hdr_frm) >= MaxFramesPerCol);

  // Oldest word migrates to the top slice as later words enter at the LSBs.
  generate
    if (NumRows > 1) begin : g_shift
      assign shifted = {frame_q[FRAME_W-FrameBitsPerRow-1:0], WordData};
    end else begin : g_single
      assign shifted = WordData;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    col_d   = col_q;
    frm_d   = frm_q;
    drop_d  = drop_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    error_d = error_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (WordData == SyncWord)) begin
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (accept) begin
          if (!WordData[WRITE_BIT]) begin
            state_d = ST_IDLE;
          end else begin
            col_d   = hdr_col;
            frm_d   = hdr_frm;
            drop_d  = hdr_drop;
            wcnt_d  = '0;
            error_d = error_q | hdr_drop;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          frame_d = shifted;
          if (wcnt_q == LAST_WORD) begin
            // A dropped frame still consumes its data words but never strobes.
            state_d = drop_q ? ST_HEADER : ST_STROBE;
            scnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_STROBE: begin
        if (scnt_q == LAST_STROBE) begin
          count_d = count_q + 16'd1;
          state_d = ST_HEADER;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      col_q   <= '0;
      frm_q   <= '0;
      drop_q  <= 1'b0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      col_q   <= col_d;
      frm_q   <= frm_d;
      drop_q  <= drop_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  frame_strobe_decoder #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_strobe_dec (
    .column_i (col_q),
    .frame_i  (frm_q),
    .enable_i (state_q == ST_STROBE),
    .strobe_o (FrameStrobe)
  );

  assign FrameData  = frame_q;
  assign Active     = (state_q != ST_IDLE);
  assign Error      = error_q;
  assign FrameCount = count_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Self-checking bench for frame_config_writer: directed scenarios plus a random
// word stream, all checked against a word-level interpreter of the protocol.
module tb_frame_config_writer;

  localparam int          FB   = 32;
  localparam int          NR   = 4;
  localparam int          MF   = 20;
  localparam int          NC   = 4;
  localparam int          SC   = 2;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK   = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   WordData = '0;
  logic          WordValid = 1'b0;
  logic          WordReady;
  logic [127:0]  FrameData;
  logic [79:0]   FrameStrobe;
  logic          Active;
  logic          Error;
  logic [15:0]   FrameCount;

  int nvec  = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  frame_config_writer #(
    .FrameBitsPerRow (FB),
    .NumRows         (NR),
    .MaxFramesPerCol (MF),
    .NumColumns      (NC),
    .StrobeCycles    (SC),
    .SyncWord        (SYNC)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .WordData    (WordData),
    .WordValid   (WordValid),
    .WordReady   (WordReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Active      (Active),
    .Error       (Error),
    .FrameCount  (FrameCount)
  );

  // Word-level reference: what each accepted word means, with no notion of cycles.
  bit           m_sync, m_in_frame, m_drop, m_err;
  int           m_col, m_frm, m_words;
  logic [127:0] m_data;
  logic [15:0]  m_count;

  function automatic void model_reset();
    m_sync = 0; m_in_frame = 0; m_drop = 0; m_err = 0;
    m_col = 0; m_frm = 0; m_words = 0;
    m_data = '0; m_count = '0;
  endfunction

  function automatic logic [79:0] model_word(input logic [31:0] w);
    logic [79:0] s;
    s = '0;
    if (!m_sync) begin
      m_sync = (w == SYNC);
    end else if (!m_in_frame) begin
      if (!w[31]) begin
        m_sync = 0;
      end else begin
        m_col = int'(w[23:16]);
        m_frm = int'(w[15:8]);
        m_drop = (m_col >= NC) || (m_frm >= MF);
        m_err = m_err | m_drop;
        m_in_frame = 1;
        m_words = 0;
      end
    end else begin
      m_data = {m_data[95:0], w};
      m_words++;
      if (m_words == NR) begin
        m_in_frame = 0;
        if (!m_drop) begin
          s = 80'(1) << (m_col * MF + m_frm);
          m_count = m_count + 16'd1;
        end
      end
    end
    return s;
  endfunction

  // Observations captured by drive_word after each accepted word.
  logic [79:0]  obs_strobe, obs_tail;
  logic [127:0] obs_data;
  logic [15:0]  obs_count;
  logic         obs_active, obs_error;
  int           obs_len;

  task automatic apply_reset();
    reset = 1'b1;
    WordValid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  // Entered and left at a falling edge; inputs change only there.
  task automatic drive_word(input logic [31:0] w, input bit stall);
    int waitc;
    bit rdy;
    WordData = w;
    WordValid = 1'b1;
    waitc = 0;
    forever begin
      rdy = WordReady;
      @(posedge CLK);
      if (rdy) break;
      @(negedge CLK);
      waitc++;
      if (waitc > 20) begin
        nvec++; nfail++;
        $display("FAIL handshake_timeout word=%h: WordReady=%b, required 1", w, WordReady);
        WordValid = 1'b0;
        return;
      end
    end
    @(negedge CLK);
    WordValid = 1'b0;
    obs_strobe = FrameStrobe;
    obs_active = Active;
    obs_error  = Error;
    obs_data   = FrameData;
    obs_len    = 0;
    if (FrameStrobe != '0) begin
      while (FrameStrobe == obs_strobe && !WordReady && FrameData == obs_data && obs_len < 10) begin
        obs_len++;
        @(negedge CLK);
      end
    end
    obs_tail  = FrameStrobe;
    obs_count = FrameCount;
    if (stall) begin
      WordData = $urandom;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    nvec++; if (FrameData !== '0)   begin nfail++; $display("FAIL reset_framedata: got %h, required 0", FrameData); end
    nvec++; if (FrameStrobe !== '0) begin nfail++; $display("FAIL reset_strobe: got %h, required 0", FrameStrobe); end
    nvec++; if (Active !== 1'b0)    begin nfail++; $display("FAIL reset_active: got %b, required 0", Active); end
    nvec++; if (Error !== 1'b0)     begin nfail++; $display("FAIL reset_error: got %b, required 0", Error); end
    nvec++; if (FrameCount !== '0)  begin nfail++; $display("FAIL reset_count: got %h, required 0", FrameCount); end
    nvec++; if (WordReady !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b, required 1", WordReady); end
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_frame();
    logic [31:0] ws[$];
    logic [79:0] exp_s;
    apply_reset();
    ws = {SYNC, 32'h8001_0300, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    foreach (ws[i]) begin
      drive_word(ws[i], 1'b0);
      exp_s = model_word(ws[i]);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL basic_strobe w%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 i, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL basic_state w%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 i, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
    nvec++;
    if (obs_strobe !== (80'(1) << 23) || FrameData !== 128'h11111111_22222222_33333333_44444444 ||
        FrameCount !== 16'd1 || Error !== 1'b0) begin
      nfail++;
      $display("FAIL basic_literal: strobe=%h data=%h cnt=%0d err=%b, required bit23 data=1111..4444 cnt=1 err=0",
               obs_strobe, FrameData, FrameCount, Error);
    end
  endtask

  task automatic test_presync_garbage();
    logic [31:0] ws[$];
    logic [79:0] exp_s;
    apply_reset();
    ws = {32'h1234_5678, 32'hDEAD_BEEF, SYNC, 32'h8000_0000, $urandom, $urandom, $urandom, $urandom};
    foreach (ws[i]) begin
      drive_word(ws[i], 1'b0);
      exp_s = model_word(ws[i]);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL garbage_strobe w%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 i, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL garbage_state w%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 i, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ws[$];
    logic [79:0] exp_s;
    apply_reset();
    ws = {SYNC, 32'h8004_0000, $urandom, $urandom, $urandom, $urandom,
          32'h8000_1400, $urandom, $urandom, $urandom, $urandom,
          32'h8002_0500, $urandom, $urandom, $urandom, $urandom};
    foreach (ws[i]) begin
      drive_word(ws[i], 1'b0);
      exp_s = model_word(ws[i]);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL range_strobe w%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 i, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL range_state w%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 i, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
    nvec++;
    if (Error !== 1'b1 || FrameCount !== 16'd1) begin
      nfail++;
      $display("FAIL range_final: err=%b cnt=%0d, required err=1 cnt=1", Error, FrameCount);
    end
  endtask

  task automatic test_desync_back_to_back();
    logic [31:0] ws[$];
    logic [79:0] exp_s;
    apply_reset();
    ws = {SYNC, 32'h8003_1300, $urandom, $urandom, $urandom, $urandom,
          32'h8000_0100, $urandom, $urandom, $urandom, $urandom,
          32'h0000_0000, 32'h5555_5555, 32'h8001_0000};
    foreach (ws[i]) begin
      drive_word(ws[i], 1'b0);
      exp_s = model_word(ws[i]);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL b2b_strobe w%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 i, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL b2b_state w%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 i, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
    nvec++;
    if (FrameCount !== 16'd2 || Active !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_final: cnt=%0d act=%b, required cnt=2 act=0", FrameCount, Active);
    end
  endtask

  task automatic test_stalled_source();
    logic [31:0] ws[$];
    logic [79:0] exp_s;
    apply_reset();
    ws = {SYNC, 32'h8001_0300, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    foreach (ws[i]) begin
      drive_word(ws[i], i >= 2);
      exp_s = model_word(ws[i]);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL stall_strobe w%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 i, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL stall_state w%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 i, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
    nvec++;
    if (FrameData !== 128'h11111111_22222222_33333333_44444444 || FrameCount !== 16'd1) begin
      nfail++;
      $display("FAIL stall_final: data=%h cnt=%0d, required data=1111..4444 cnt=1", FrameData, FrameCount);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    drive_word(SYNC, 1'b0);
    drive_word(32'h8005_0000, 1'b0);
    for (int i = 0; i < NR; i++) drive_word($urandom, 1'b0);
    drive_word(32'h8001_0300, 1'b0);
    drive_word(32'hA5A5_0001, 1'b0);
    drive_word(32'hA5A5_0002, 1'b0);
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({FrameData, FrameStrobe, Active, Error, FrameCount, WordReady} !== {128'h0, 80'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      nfail++;
      $display("FAIL rst_mid_frame: data=%h strobe=%h act=%b err=%b cnt=%0d rdy=%b, required all 0 and rdy=1",
               FrameData, FrameStrobe, Active, Error, FrameCount, WordReady);
    end
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    drive_word(32'h8001_0300, 1'b0);
    nvec++;
    if (obs_active !== 1'b0 || obs_strobe !== '0) begin
      nfail++;
      $display("FAIL rst_mid_frame_idle: act=%b strobe=%h, required act=0 strobe=0", obs_active, obs_strobe);
    end
  endtask

  task automatic test_reset_mid_strobe();
    apply_reset();
    drive_word(SYNC, 1'b0);
    drive_word(32'h8002_0700, 1'b0);
    for (int i = 0; i < NR - 1; i++) drive_word($urandom, 1'b0);
    WordData = 32'hC0DE_0004;
    WordValid = 1'b1;
    @(posedge CLK);
    #1 WordValid = 1'b0;
    nvec++;
    if (FrameStrobe !== (80'(1) << 47)) begin
      nfail++;
      $display("FAIL rst_strobe_pre: strobe=%h, required bit47", FrameStrobe);
    end
    reset = 1'b1;
    #1;
    nvec++;
    if ({FrameData, FrameStrobe, Active, Error, FrameCount, WordReady} !== {128'h0, 80'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      nfail++;
      $display("FAIL rst_mid_strobe: data=%h strobe=%h act=%b err=%b cnt=%0d rdy=%b, required all 0 and rdy=1",
               FrameData, FrameStrobe, Active, Error, FrameCount, WordReady);
    end
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge CLK);
    nvec++;
    if (FrameStrobe !== '0 || FrameCount !== 16'd0 || Active !== 1'b0) begin
      nfail++;
      $display("FAIL rst_strobe_after: strobe=%h cnt=%0d act=%b, required 0 0 0", FrameStrobe, FrameCount, Active);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [79:0] exp_s;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      if (!m_sync) begin
        w = ($urandom_range(0, 3) == 0) ? $urandom : SYNC;
      end else if (!m_in_frame) begin
        if ($urandom_range(0, 9) == 0) w = $urandom & 32'h7FFF_FFFF;
        else w = {1'b1, 7'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 23)), 8'($urandom)};
      end else begin
        w = $urandom;
      end
      drive_word(w, $urandom_range(0, 3) == 0);
      exp_s = model_word(w);
      nvec++;
      if (obs_strobe !== exp_s || obs_len != ((exp_s != '0) ? SC : 0) || obs_tail !== '0) begin
        nfail++;
        $display("FAIL rand_strobe n%0d: strobe=%h len=%0d tail=%h, required strobe=%h len=%0d tail=0",
                 n, obs_strobe, obs_len, obs_tail, exp_s, (exp_s != '0) ? SC : 0);
      end
      nvec++;
      if ({obs_active, obs_error, obs_count, obs_data} !== {m_sync, m_err, m_count, m_data}) begin
        nfail++;
        $display("FAIL rand_state n%0d: act=%b err=%b cnt=%0d data=%h, required act=%b err=%b cnt=%0d data=%h",
                 n, obs_active, obs_error, obs_count, obs_data, m_sync, m_err, m_count, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_presync_garbage();
    test_out_of_range();
    test_desync_back_to_back();
    test_stalled_source();
    test_reset_mid_frame();
    test_reset_mid_strobe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
